// File: rtl/rob_commit_if.sv
// Reorder-buffer bundle: dispatch allocation, writeback, flush, and
// the commit port that drives the register file write side.
interface rob_commit_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 3
);
  logic             alloc_valid;
  logic [4:0]       alloc_rd;
  logic             alloc_ready;
  logic [TAG_W-1:0] alloc_tag;

  logic             wb_valid;
  logic [TAG_W-1:0] wb_tag;
  logic [WIDTH-1:0] wb_data;

  logic             flush;

  logic             commit_w_en;
  logic [4:0]       commit_rd_addr;
  logic [WIDTH-1:0] commit_w_data;

  logic [TAG_W:0]   count;
  logic             empty;
  logic             full;

  // Core side: dispatch, execution units and flush control.
  modport master (
    output alloc_valid, alloc_rd, wb_valid, wb_tag, wb_data, flush,
    input  alloc_ready, alloc_tag, commit_w_en, commit_rd_addr, commit_w_data,
           count, empty, full
  );

  // Reorder buffer side.
  modport slave (
    input  alloc_valid, alloc_rd, wb_valid, wb_tag, wb_data, flush,
    output alloc_ready, alloc_tag, commit_w_en, commit_rd_addr, commit_w_data,
           count, empty, full
  );
endinterface

// File: rtl/rob_commit.sv
// Reorder buffer: in-order allocation, out-of-order writeback by tag,
// in-order retirement of at most one entry per cycle straight into the
// register file write port.
module rob_commit #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int TAG_W = $clog2(DEPTH)
) (
  input logic        clk,
  input logic        reset,
  rob_commit_if.slave rob
);

  typedef logic [TAG_W:0] ptr_t;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  ptr_t             head_ptr;
  ptr_t             tail_ptr;
  logic [TAG_W-1:0] head_idx;
  logic [TAG_W-1:0] tail_idx;

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] done_q;
  logic [4:0]       rd_q   [DEPTH];
  logic [WIDTH-1:0] data_q [DEPTH];

  logic full_w;
  logic alloc_fire;
  logic wb_fire;
  logic commit_fire;

  assign head_idx = head_ptr[TAG_W-1:0];
  assign tail_idx = tail_ptr[TAG_W-1:0];

  assign full_w = (head_idx == tail_idx) && (head_ptr[TAG_W] != tail_ptr[TAG_W]);

  // Flush suppresses every operation in its cycle, including commit.
  assign alloc_fire  = rob.alloc_valid && !full_w && !rob.flush;
  assign wb_fire     = rob.wb_valid && valid_q[rob.wb_tag] && !rob.flush;
  assign commit_fire = valid_q[head_idx] && done_q[head_idx] && !rob.flush;

  // Status outputs derived purely from the pointers.
  assign rob.count       = tail_ptr - head_ptr;
  assign rob.empty       = (head_ptr == tail_ptr);
  assign rob.full        = full_w;
  assign rob.alloc_ready = !full_w;
  assign rob.alloc_tag   = tail_idx;

  // Commit port: head entry payload gated to zero when not retiring.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned and infers a latch.
    rob.commit_w_en    = 1'b0;
    rob.commit_rd_addr = '0;
    rob.commit_w_data  = '0;
    if (commit_fire) begin
      rob.commit_w_en    = 1'b1;
      rob.commit_rd_addr = rd_q[head_idx];
      rob.commit_w_data  = data_q[head_idx];
    end
  end

  // Pointer update: reset and flush rewind both, otherwise advance independently.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset || rob.flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
    end else begin
      if (commit_fire) head_ptr <= head_ptr + ptr_t'(1);
      if (alloc_fire)  tail_ptr <= tail_ptr + ptr_t'(1);
    end
  end

  // Entry status bits: allocate sets valid, writeback sets done, commit retires.
  always_ff @(posedge clk) begin
    if (reset || rob.flush) begin
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      if (commit_fire) valid_q[head_idx] <= 1'b0;
      if (alloc_fire) begin
        valid_q[tail_idx] <= 1'b1;
        done_q[tail_idx]  <= 1'b0;
      end
      if (wb_fire) done_q[rob.wb_tag] <= 1'b1;
    end
  end

  // Entry payload: destination captured at allocation, result at writeback.
  always_ff @(posedge clk) begin
    // NOTE: payload arrays are not reset; valid/done gate every use, so stale contents are never observed.
    if (alloc_fire) rd_q[tail_idx]     <= rob.alloc_rd;
    if (wb_fire)    data_q[rob.wb_tag] <= rob.wb_data;
  end

endmodule

// File: tb/tb_rob_commit.sv
// Bench for rob_commit: directed scenarios plus randomized traffic, all
// checked every cycle against an in-order queue model of the buffer.
module tb_rob_commit;
  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int TAG_W = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;

  rob_commit_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

  rob_commit #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .reset (reset),
    .rob   (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: program-ordered list of live instructions, oldest first.
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [4:0]       rd;
    logic             done;
    logic [WIDTH-1:0] data;
  } ent_t;

  ent_t q[$];
  int   next_tag = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Outputs the buffer must show for the current model state and inputs.
  task automatic compare();
    ent_t h;
    logic ew;
    h  = (q.size() > 0) ? q[0] : '0;
    ew = !bus.flush && (q.size() > 0) && h.done;
    check("alloc_ready", 32'(bus.alloc_ready), 32'(q.size() < DEPTH));
    check("alloc_tag",   32'(bus.alloc_tag),   32'(next_tag));
    check("count",       32'(bus.count),       32'(q.size()));
    check("empty",       32'(bus.empty),       32'(q.size() == 0));
    check("full",        32'(bus.full),        32'(q.size() == DEPTH));
    check("commit_w_en", 32'(bus.commit_w_en), 32'(ew));
    check("commit_rd",   32'(bus.commit_rd_addr), ew ? 32'(h.rd) : 32'd0);
    check("commit_data", bus.commit_w_data,    ew ? h.data : 32'd0);
  endtask

  // Model update at the clock edge from the inputs held across it.
  task automatic model_tick();
    int   n;
    logic com;
    if (reset || bus.flush) begin
      q.delete();
      next_tag = 0;
      return;
    end
    n   = q.size();
    com = (n > 0) && q[0].done;
    if (bus.wb_valid)
      foreach (q[i]) if (q[i].tag == bus.wb_tag) begin
        q[i].done = 1'b1;
        q[i].data = bus.wb_data;
      end
    if (com) void'(q.pop_front());
    if (bus.alloc_valid && n < DEPTH) begin
      q.push_back('{tag: TAG_W'(next_tag), rd: bus.alloc_rd, done: 1'b0, data: '0});
      next_tag = (next_tag + 1) % DEPTH;
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] ard, input logic wv,
                       input logic [TAG_W-1:0] wt, input logic [31:0] wd, input logic fl);
    @(negedge clk);
    reset           = 1'b0;
    bus.alloc_valid = av;
    bus.alloc_rd    = ard;
    bus.wb_valid    = wv;
    bus.wb_tag      = wt;
    bus.wb_data     = wd;
    bus.flush       = fl;
    #1;
    compare();
  endtask

  task automatic tick();
    @(posedge clk);
    model_tick();
  endtask

  task automatic step(input logic av, input logic [4:0] ard, input logic wv,
                      input logic [TAG_W-1:0] wt, input logic [31:0] wd, input logic fl);
    drive(av, ard, wv, wt, wd, fl);
    tick();
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 1'b0, '0, 32'd0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset           = 1'b1;
    bus.alloc_valid = 1'($urandom_range(0, 1));
    bus.alloc_rd    = 5'($urandom);
    bus.wb_valid    = 1'($urandom_range(0, 1));
    bus.wb_tag      = TAG_W'($urandom);
    bus.wb_data     = $urandom;
    bus.flush       = 1'b0;
    tick();
  endtask

  initial begin
    bus.alloc_valid = 1'b0;
    bus.alloc_rd    = '0;
    bus.wb_valid    = 1'b0;
    bus.wb_tag      = '0;
    bus.wb_data     = '0;
    bus.flush       = 1'b0;

    // In-order commit after in-order writeback.
    do_reset();
    drive(1'b0, 5'd0, 1'b0, '0, 32'd0, 1'b0);
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_full", 32'(bus.full), 32'd0);
    check("rst_ready", 32'(bus.alloc_ready), 32'd1);
    check("rst_tag", 32'(bus.alloc_tag), 32'd0);
    check("rst_w_en", 32'(bus.commit_w_en), 32'd0);
    check("rst_rd", 32'(bus.commit_rd_addr), 32'd0);
    check("rst_data", bus.commit_w_data, 32'd0);
    tick();
    for (int i = 1; i <= 3; i++) step(1'b1, 5'(i), 1'b0, '0, 32'd0, 1'b0);
    step(1'b0, 5'd0, 1'b1, 3'd0, 32'hA, 1'b0);
    drive(1'b0, 5'd0, 1'b1, 3'd1, 32'hB, 1'b0);
    check("t1_c0_en", 32'(bus.commit_w_en), 32'd1);
    check("t1_c0_rd", 32'(bus.commit_rd_addr), 32'd1);
    check("t1_c0_data", bus.commit_w_data, 32'hA);
    tick();
    drive(1'b0, 5'd0, 1'b1, 3'd2, 32'hC, 1'b0);
    check("t1_c1_data", bus.commit_w_data, 32'hB);
    tick();
    drive(1'b0, 5'd0, 1'b0, '0, 32'd0, 1'b0);
    check("t1_c2_rd", 32'(bus.commit_rd_addr), 32'd3);
    check("t1_c2_data", bus.commit_w_data, 32'hC);
    tick();
    drive(1'b0, 5'd0, 1'b0, '0, 32'd0, 1'b0);
    check("t1_count0", 32'(bus.count), 32'd0);
    tick();

    // Out-of-order writeback, head blocks younger done entries.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 5'(4 + i), 1'b0, '0, 32'd0, 1'b0);
    step(1'b0, 5'd0, 1'b1, 3'd2, 32'h22, 1'b0);
    drive(1'b0, 5'd0, 1'b1, 3'd1, 32'h11, 1'b0);
    check("t2_hold", 32'(bus.commit_w_en), 32'd0);
    tick();
    step(1'b0, 5'd0, 1'b1, 3'd0, 32'h10, 1'b0);
    for (int i = 0; i < 4; i++) idle();

    // Fill, ignore allocation while full, then wrap the tail.
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 5'(i + 1), 1'b0, '0, 32'd0, 1'b0);
    drive(1'b1, 5'd30, 1'b0, '0, 32'd0, 1'b0);
    check("t3_full", 32'(bus.full), 32'd1);
    check("t3_ready", 32'(bus.alloc_ready), 32'd0);
    check("t3_count", 32'(bus.count), 32'd8);
    tick();
    step(1'b0, 5'd0, 1'b1, 3'd0, 32'h55, 1'b0);
    drive(1'b1, 5'd29, 1'b0, '0, 32'd0, 1'b0);
    check("t3_no_reuse", 32'(bus.alloc_ready), 32'd0);
    tick();
    drive(1'b1, 5'd31, 1'b0, '0, 32'd0, 1'b0);
    check("t3_wrap_tag", 32'(bus.alloc_tag), 32'd0);
    tick();
    drive(1'b0, 5'd0, 1'b0, '0, 32'd0, 1'b0);
    check("t3_full_again", 32'(bus.full), 32'd1);
    tick();

    // Streaming: allocate, write back previous tag, commit every cycle.
    do_reset();
    step(1'b1, 5'd1, 1'b0, '0, 32'd0, 1'b0);
    for (int i = 0; i < 20; i++)
      step(1'b1, 5'($urandom), 1'b1, TAG_W'((next_tag + DEPTH - 1) % DEPTH), $urandom, 1'b0);
    drive(1'b0, 5'd0, 1'b0, '0, 32'd0, 1'b0);
    check("t4_steady", 32'(bus.count), 32'd2);
    tick();

    // Flush with a done head entry.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 5'(i + 8), 1'b0, '0, 32'd0, 1'b0);
    step(1'b0, 5'd0, 1'b1, 3'd1, 32'h77, 1'b0);
    step(1'b0, 5'd0, 1'b1, 3'd0, 32'h66, 1'b0);
    drive(1'b1, 5'd3, 1'b1, 3'd2, 32'h88, 1'b1);
    check("t5_flush_w_en", 32'(bus.commit_w_en), 32'd0);
    tick();
    drive(1'b0, 5'd0, 1'b1, 3'd1, 32'h99, 1'b0);
    check("t5_count", 32'(bus.count), 32'd0);
    check("t5_empty", 32'(bus.empty), 32'd1);
    tick();
    drive(1'b1, 5'd9, 1'b0, '0, 32'd0, 1'b0);
    check("t5_tag0", 32'(bus.alloc_tag), 32'd0);
    tick();
    drive(1'b0, 5'd0, 1'b0, '0, 32'd0, 1'b0);
    check("t5_stale_wb", 32'(bus.commit_w_en), 32'd0);
    tick();

    // rd = 0 still commits.
    do_reset();
    step(1'b1, 5'd0, 1'b0, '0, 32'd0, 1'b0);
    step(1'b0, 5'd0, 1'b1, 3'd0, 32'hFFFF_FFFF, 1'b0);
    drive(1'b0, 5'd0, 1'b0, '0, 32'd0, 1'b0);
    check("t6_w_en", 32'(bus.commit_w_en), 32'd1);
    check("t6_rd", 32'(bus.commit_rd_addr), 32'd0);
    check("t6_data", bus.commit_w_data, 32'hFFFF_FFFF);
    tick();

    // Randomized traffic with occasional flush and mid-run reset.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      else step(1'($urandom_range(0, 9) < 6), 5'($urandom),
                1'($urandom_range(0, 9) < 6), TAG_W'($urandom), $urandom,
                1'($urandom_range(0, 99) < 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/rob_commit.md
# rob_commit

Reorder buffer feeding the register file's single synchronous write port in the out-of-order core. Dispatch allocates entries in program order. Execution units write results back out of order, tagged by entry index. The head entry retires in order, at most one per cycle, by driving the register file's w_en / rd_addr / w_data directly, so architectural state changes only at commit.

## Interface
Parameters:
- WIDTH, 32, data width of results; must match the register file WIDTH.
- DEPTH, 8, number of entries; power of 2, minimum 2.
- TAG_W, $clog2(DEPTH), entry tag width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- alloc_valid  in  1  dispatch requests an entry this cycle.
- alloc_rd  in  5  destination architectural register of the allocating instruction.
- alloc_ready  out  1  entry available; equals !full.
- alloc_tag  out  TAG_W  tag granted to the allocation; equals the tail index.
- wb_valid  in  1  result writeback this cycle.
- wb_tag  in  TAG_W  entry being written back.
- wb_data  in  WIDTH  result value.
- flush  in  1  discard all entries (mispredict or exception).
- commit_w_en  out  1  to register file w_en.
- commit_rd_addr  out  5  to register file rd_addr.
- commit_w_data  out  WIDTH  to register file w_data.
- count  out  TAG_W+1  number of occupied entries.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.

## Operation
- Storage: circular array of DEPTH entries. Each entry holds valid, done, rd[4:0] and data[WIDTH-1:0].
- Pointers: head_ptr and tail_ptr, each TAG_W+1 bits wide. The MSB is the wrap bit.
  - empty when the pointers are equal.
  - full when the low bits are equal and the MSBs differ.
  - count = tail_ptr − head_ptr, computed modulo 2^(TAG_W+1).
- Allocate on alloc_valid && alloc_ready:
  - Entry[tail] is set to valid=1, done=0, rd=alloc_rd.
  - tail_ptr increments.
  - An alloc_valid while full is ignored, with no state change.
- Writeback on wb_valid:
  - If entry[wb_tag] is valid, set done=1 and data=wb_data.
  - If the entry is not valid, the writeback is ignored.
  - A repeat writeback to an already-done entry overwrites the data.
- Commit is combinational from registered state:
  - commit_w_en = entry[head].valid && entry[head].done && !flush.
  - commit_rd_addr = entry[head].rd and commit_w_data = entry[head].data whenever commit_w_en=1; both are 0 otherwise.
  - On any edge where commit_w_en=1, entry[head].valid clears and head_ptr increments. The register file captures the write on the same edge.
- Entries with rd=0 still commit with commit_w_en=1. The register file discards writes to x0.
- Allocate, writeback and commit may all occur in one cycle and are independent.
  - A commit and an allocate in the same cycle leave count unchanged.
  - When full, alloc_ready=0 even if a commit occurs that cycle. There is no same-cycle slot reuse.
- Priority: reset > flush > all other operations.
  - Flush clears every valid and done bit and sets head_ptr = tail_ptr = 0.
  - In the flush cycle, commit_w_en=0 and alloc/wb are ignored.
- Pointer wrap: the index wraps from DEPTH−1 to 0 and the wrap bit toggles. Tags reuse freely after wrap.

## Timing
- Reset values: all entries invalid, head_ptr=tail_ptr=0, count=0, empty=1, full=0, alloc_ready=1, alloc_tag=0, commit_w_en=0, commit_rd_addr=0, commit_w_data=0.
- Reset applied mid-operation discards all entries, with the same behaviour as flush.
- alloc_tag is valid in the same cycle as alloc_valid. The entry exists from the next edge.
- Writeback at edge N for the head entry: commit_w_en is high during cycle N+1, and the entry retires at edge N+1. Writeback-to-commit latency is therefore 1 cycle.
- There is no same-cycle bypass from wb_* to commit_*. The earliest commit is two edges after allocation.
- The head holds while not done; younger done entries wait. The block sustains 1 commit per cycle.

## Test plan
- Reset, then 3 allocations with rd=1,2,3, then writebacks to tags 0,1,2 with 0xA,0xB,0xC -> commits (1,0xA),(2,0xB),(3,0xC) on consecutive cycles; count returns to 0.
- Allocate tags 0..2, write back tag 2 then 1 then 0 -> no commit until tag 0 is done; then 3 back-to-back commits in order 0,1,2.
- Allocate 8 entries -> full=1, alloc_ready=0, count=8. A 9th alloc_valid is ignored. One commit followed by one alloc -> tail wraps, alloc_tag=0, full=1 again.
- Streaming: every cycle alloc, write back the previous tag, and commit, for 20 cycles (DEPTH=8) -> tags wrap twice, commit order and data match, count stays steady.
- 5 entries with 2 done, then flush asserted -> commit_w_en=0 in the flush cycle, count=0 and empty=1 next cycle, a later wb to an old tag is ignored, and the next alloc_tag=0.
- Commit an entry with rd=0 and data 0xFFFF_FFFF -> commit_w_en=1 with rd_addr=0; the paired register file still reads x0 = 0.
